multi_cycle_sequencer206: RTL and testbench
===========================================

# multi_cycle_sequencer206

Multi-cycle control sequencer that converts the CPU core from single-cycle to multi-cycle operation over a shared, handshaked memory port. It sits between the instruction decoder and the datapath. It consumes the decoder's instruction-class signals and produces per-step write enables (IR, PC, register file, memory), the memory request and handshake, and the PC source select. It also keeps a retired-instruction counter and traps on memory timeouts.

## Interface
- MEM_TIMEOUT, default 16: maximum wait cycles for `mem_ready` per access; 0 disables the timeout.
- CNT_W, default 32: width of the retired-instruction counter.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  fetch enable, sampled only at instruction boundaries
- mem_ready  in  1  memory acknowledge for the current request
- is_jump  in  1  decoded J/Jal/Rtype_J instruction
- is_branch  in  1  decoded conditional branch
- branch_taken  in  1  branch condition from datapath ALU
- is_load  in  1  decoded load (word or byte)
- is_store  in  1  decoded store (word or byte)
- reg_wr  in  1  decoded RegWr for the current instruction
- mem_req  out  1  memory access request
- mem_we  out  1  memory write strobe (data stores only)
- mem_sel_data  out  1  address select: 0 = PC (fetch), 1 = ALU result (data)
- ir_wr  out  1  instruction register load
- pc_wr  out  1  PC update
- pc_src  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target
- reg_wr_en  out  1  register file write enable
- state  out  3  current state encoding
- busy  out  1  high in every state except IDLE and FAULT
- fault  out  1  memory timeout trap, sticky until reset
- retired  out  1  one-cycle pulse per completed instruction
- retire_cnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Encoding 6 is illegal and goes to FAULT.
- IDLE: all strobes low. Go to FETCH when `run`=1.
- FETCH: `mem_req`=1, `mem_sel_data`=0, `mem_we`=0.
  - When `mem_ready`=1: `ir_wr`=1 combinationally in that same cycle; go to DECODE.
- DECODE: one cycle with no strobes; go to EXEC. Decoder inputs are stable from this point because the IR is held.
- EXEC: decode priority is `is_jump` > `is_branch` > `is_load`/`is_store` > ALU.
  - Jump: `pc_wr`=1, `pc_src`=10, `reg_wr_en`=`reg_wr` (link write); retire.
  - Branch: `pc_wr`=1, `pc_src`=01 if `branch_taken` else 00; retire.
  - Load or store: go to MEM.
  - ALU: go to WB.
- MEM: `mem_req`=1, `mem_sel_data`=1, `mem_we`=`is_store`.
  - On `mem_ready`, store: `pc_wr`=1, `pc_src`=00; retire.
  - On `mem_ready`, load: go to WB.
- WB: `reg_wr_en`=`reg_wr`, `pc_wr`=1, `pc_src`=00; retire.
- Retire: `retired`=1 for one cycle and `retire_cnt` increments. Next state is FETCH if `run`=1, else IDLE. Deasserting `run` mid-instruction never aborts the instruction.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_ready`=0.
  - If the counter reaches MEM_TIMEOUT-1 with `mem_ready` still 0, the next state is FAULT.
  - FAULT: `fault`=1, all strobes 0. Exit only by reset.
- `pc_src` is 00 whenever `pc_wr`=0.

## Timing
- Reset values: `state`=IDLE, `retire_cnt`=0, wait counter 0, every output 0.
- Reset mid-operation takes effect immediately. `mem_req`, `mem_we`, `pc_wr` and `reg_wr_en` drop asynchronously. No partial write may complete.
- All strobes decode from registered state plus same-cycle `mem_ready`, `branch_taken` and `reg_wr`. There is no registered output delay.
- Latency with zero-wait memory, counted from FETCH entry to the retire cycle inclusive: branch/jump 3, ALU 4, store 4, load 5. Each wait cycle adds 1.
- Back-to-back: when `run` stays 1, the cycle after a retire is FETCH.
- `mem_ready` is ignored outside FETCH and MEM.
- `retire_cnt` wraps from 2^CNT_W-1 to 0 without flags.

## Test plan
- Reset, then `run`=1, ALU instruction, `mem_ready`=1 always: states go 1,2,3,5. `reg_wr_en`=1 and `pc_wr`=1 in WB. `retire_cnt`=1 after 4 cycles.
- Load with `mem_ready` low for 3 cycles in MEM: MEM lasts 4 cycles with `mem_sel_data`=1 and `mem_we`=0. Then WB. Total 8 cycles.
- Store followed by a taken branch (`branch_taken`=1): `mem_we`=1 only in MEM. The branch retires in EXEC with `pc_src`=01. `retire_cnt`=2 after 7 cycles.
- Jal with `reg_wr`=1: in EXEC, `pc_src`=10 and `reg_wr_en`=1. `run` dropped during DECODE: the instruction still retires, then IDLE with `busy`=0.
- MEM_TIMEOUT=16 with `mem_ready` held 0 in FETCH: after 16 cycles, `state`=7 and `fault`=1. `mem_req`=0 until reset.
- Assert `rst` during MEM with `mem_we`=1: `mem_we` falls the same cycle. After release, all outputs are 0, `retire_cnt`=0, `state`=0.

Source files
------------

// File: rtl/multi_cycle_sequencer206_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_sequencer206_if
// Brief    : Decoder, memory handshake and datapath control bundle for the
//            multi-cycle sequencer. The master side is the sequencer itself;
//            the slave side is its environment (decoder, memory, datapath).
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_sequencer206_if #(
    parameter int CNT_W = 32
) ();
    // Environment -> sequencer
    logic             run;
    logic             mem_ready;
    logic             is_jump;
    logic             is_branch;
    logic             branch_taken;
    logic             is_load;
    logic             is_store;
    logic             reg_wr;

    // Sequencer -> environment
    logic             mem_req;
    logic             mem_we;
    logic             mem_sel_data;
    logic             ir_wr;
    logic             pc_wr;
    logic [1:0]       pc_src;
    logic             reg_wr_en;
    logic [2:0]       state;
    logic             busy;
    logic             fault;
    logic             retired;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  run, mem_ready, is_jump, is_branch, branch_taken,
               is_load, is_store, reg_wr,
        output mem_req, mem_we, mem_sel_data, ir_wr, pc_wr, pc_src,
               reg_wr_en, state, busy, fault, retired, retire_cnt
    );

    modport slave (
        output run, mem_ready, is_jump, is_branch, branch_taken,
               is_load, is_store, reg_wr,
        input  mem_req, mem_we, mem_sel_data, ir_wr, pc_wr, pc_src,
               reg_wr_en, state, busy, fault, retired, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_sequencer206.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_sequencer206
// Brief    : Multi-cycle control sequencer. Walks each instruction through
//            FETCH/DECODE/EXEC/MEM/WB over one shared handshaked memory port,
//            emits per-step write enables, counts retired instructions and
//            traps into a sticky FAULT state on a memory timeout.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_sequencer206 #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    multi_cycle_sequencer206_if.master  bus
);

    // Encoding 6 is unused; it falls into the default branch and traps.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam int                c_WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] c_SRC_SEQ    = 2'b00;
    localparam logic [1:0] c_SRC_BRANCH = 2'b01;
    localparam logic [1:0] c_SRC_JUMP   = 2'b10;

    state_t              state_q, state_d;
    logic [c_WAIT_W-1:0] wait_q,  wait_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_sel_data;
    logic       w_ir_wr;
    logic       w_pc_wr;
    logic [1:0] w_pc_src;
    logic       w_reg_wr_en;
    logic       w_retire;
    logic       w_timeout;
    logic       w_in_access;

    // Only FETCH and MEM wait on the memory port.
    assign w_in_access = (state_q == S_FETCH) || (state_q == S_MEM);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout_on
            // Last permitted wait cycle has elapsed and memory still has not answered.
            assign w_timeout = (wait_q == c_WAIT_MAX) && !bus.mem_ready;
        end else begin : g_timeout_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Next-state and strobe decode from the registered state plus same-cycle inputs.
    always_comb begin
        state_d        = state_q;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_sel_data = 1'b0;
        w_ir_wr        = 1'b0;
        w_pc_wr        = 1'b0;
        w_pc_src       = c_SRC_SEQ;
        w_reg_wr_en    = 1'b0;
        w_retire       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_wr = 1'b1;
                    state_d = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                if (bus.is_jump) begin
                    w_pc_wr     = 1'b1;
                    w_pc_src    = c_SRC_JUMP;
                    w_reg_wr_en = bus.reg_wr;
                    w_retire    = 1'b1;
                end else if (bus.is_branch) begin
                    w_pc_wr  = 1'b1;
                    w_pc_src = bus.branch_taken ? c_SRC_BRANCH : c_SRC_SEQ;
                    w_retire = 1'b1;
                end else if (bus.is_load || bus.is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_sel_data = 1'b1;
                w_mem_we       = bus.is_store;
                if (bus.mem_ready) begin
                    if (bus.is_store) begin
                        w_pc_wr  = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (w_timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_WB: begin
                w_reg_wr_en = bus.reg_wr;
                w_pc_wr     = 1'b1;
                w_retire    = 1'b1;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Instruction boundary: run is only looked at here and in IDLE.
        if (w_retire) begin
            state_d = bus.run ? S_FETCH : S_IDLE;
        end
    end

    // Wait counter restarts on every new memory access and counts unanswered cycles.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wait_d = '0;
        end else if (w_in_access && !bus.mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Retired-instruction counter wraps naturally at its width.
    always_comb begin
        cnt_d = cnt_q;
        if (w_retire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, wait counter and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are masked by rst so a write in flight is cut off the instant reset rises.
    assign bus.mem_req      = w_mem_req      & ~rst;
    assign bus.mem_we       = w_mem_we       & ~rst;
    assign bus.mem_sel_data = w_mem_sel_data & ~rst;
    assign bus.ir_wr        = w_ir_wr        & ~rst;
    assign bus.pc_wr        = w_pc_wr        & ~rst;
    assign bus.pc_src       = rst ? c_SRC_SEQ : w_pc_src;
    assign bus.reg_wr_en    = w_reg_wr_en    & ~rst;
    assign bus.retired      = w_retire       & ~rst;
    assign bus.state        = state_q;
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign bus.fault        = (state_q == S_FAULT);
    assign bus.retire_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_sequencer206.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_cycle_sequencer206
// Brief    : Directed bench for multi_cycle_sequencer206. An instruction-level
//            model expands each instruction into its expected per-cycle trace;
//            a negedge compare process checks the DUT against that trace.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_sequencer206;

    localparam int CNT_W = 4;
    localparam int TO    = 16;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd7;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JMP = 4, K_JBR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_sequencer206_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_sequencer206 #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]       st;
        logic             req;
        logic             we;
        logic             sel;
        logic             irw;
        logic             pcw;
        logic [1:0]       src;
        logic             rwe;
        logic             busy;
        logic             flt;
        logic             ret;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;   // model's retired-instruction count

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st   = st;
        e.req  = 1'b0;
        e.we   = 1'b0;
        e.sel  = 1'b0;
        e.irw  = 1'b0;
        e.pcw  = 1'b0;
        e.src  = 2'b00;
        e.rwe  = 1'b0;
        e.busy = (st != ST_IDLE) && (st != ST_FAULT);
        e.flt  = (st == ST_FAULT);
        e.ret  = 1'b0;
        e.cnt  = mcnt[CNT_W-1:0];
        return e;
    endfunction

    // Compare every queued expectation half a cycle after inputs were applied.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",        bus.state,        e.st);
            check("mem_req",      bus.mem_req,      e.req);
            check("mem_we",       bus.mem_we,       e.we);
            check("mem_sel_data", bus.mem_sel_data, e.sel);
            check("ir_wr",        bus.ir_wr,        e.irw);
            check("pc_wr",        bus.pc_wr,        e.pcw);
            check("pc_src",       bus.pc_src,       e.src);
            check("reg_wr_en",    bus.reg_wr_en,    e.rwe);
            check("busy",         bus.busy,         e.busy);
            check("fault",        bus.fault,        e.flt);
            check("retired",      bus.retired,      e.ret);
            check("retire_cnt",   bus.retire_cnt,   e.cnt);
        end
    end

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Inputs whose values must not matter in the current cycle.
    task automatic scramble();
        bus.run          = 1'($urandom_range(0, 1));
        bus.mem_ready    = 1'($urandom_range(0, 1));
        bus.is_jump      = 1'($urandom_range(0, 1));
        bus.is_branch    = 1'($urandom_range(0, 1));
        bus.branch_taken = 1'($urandom_range(0, 1));
        bus.is_load      = 1'($urandom_range(0, 1));
        bus.is_store     = 1'($urandom_range(0, 1));
        bus.reg_wr       = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input bit r);
        scramble();
        bus.run = r;
        step(mk(ST_IDLE));
    endtask

    task automatic fault_tail();
        for (int k = 0; k < 4; k++) begin
            scramble();
            bus.run = 1'b1;
            step(mk(ST_FAULT));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.run = 0; bus.mem_ready = 0; bus.is_jump = 0; bus.is_branch = 0;
        bus.branch_taken = 0; bus.is_load = 0; bus.is_store = 0; bus.reg_wr = 0;
        mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH entry: fw/mw are memory wait cycles before ready.
    task automatic instr(input int kind, input bit rw, input bit tk, input int fw, input int mw,
                         input bit run_end, input bit abort, output int lat);
        exp_t e;
        bit   j, b, ld, sr;
        j   = (kind == K_JMP) || (kind == K_JBR);
        b   = (kind == K_BR)  || (kind == K_JBR);
        ld  = (kind == K_LOAD);
        sr  = (kind == K_STORE);
        lat = 0;

        for (int i = 0; i <= fw; i++) begin
            if (i == TO) begin
                fault_tail();
                return;
            end
            scramble();
            bus.mem_ready = (i == fw);
            e = mk(ST_FETCH);
            e.req = 1'b1;
            e.irw = (i == fw);
            step(e);
            lat++;
        end

        bus.is_jump = j; bus.is_branch = b; bus.is_load = ld; bus.is_store = sr;
        bus.reg_wr = rw; bus.branch_taken = tk; bus.run = run_end;
        bus.mem_ready = 1'($urandom_range(0, 1));
        step(mk(ST_DECODE));
        lat++;

        bus.mem_ready = 1'($urandom_range(0, 1));
        e = mk(ST_EXEC);
        if (j) begin
            e.pcw = 1'b1; e.src = 2'b10; e.rwe = rw; e.ret = 1'b1;
        end else if (b) begin
            e.pcw = 1'b1; e.src = tk ? 2'b01 : 2'b00; e.ret = 1'b1;
        end
        step(e);
        lat++;
        if (j || b) begin
            mcnt++;
            return;
        end

        if (ld || sr) begin
            for (int i = 0; i <= mw; i++) begin
                if (i == TO) begin
                    fault_tail();
                    return;
                end
                bus.mem_ready = (i == mw);
                e = mk(ST_MEM);
                e.req = 1'b1; e.sel = 1'b1; e.we = sr;
                if (i == mw && sr) begin
                    e.pcw = 1'b1; e.ret = 1'b1;
                end
                if (abort && i == 0 && mw > 0) begin
                    exp_q.push_back(e);
                    @(negedge clk);
                    #1;
                    rst = 1'b1;
                    #1;
                    check("rst_mem_we",  bus.mem_we,  1'b0);
                    check("rst_mem_req", bus.mem_req, 1'b0);
                    check("rst_pc_wr",   bus.pc_wr,   1'b0);
                    check("rst_state",   bus.state,   ST_IDLE);
                    mcnt = 0;
                    return;
                end
                step(e);
                lat++;
            end
            if (sr) begin
                mcnt++;
                return;
            end
        end

        bus.mem_ready = 1'($urandom_range(0, 1));
        e = mk(ST_WB);
        e.rwe = rw; e.pcw = 1'b1; e.ret = 1'b1;
        step(e);
        lat++;
        mcnt++;
    endtask

    initial begin : main
        int l1, l2;
        bus.run = 0; bus.mem_ready = 0; bus.is_jump = 0; bus.is_branch = 0;
        bus.branch_taken = 0; bus.is_load = 0; bus.is_store = 0; bus.reg_wr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        idle(1'b0);
        check("reset_cnt", bus.retire_cnt, 0);

        // ALU, zero-wait memory
        idle(1'b1);
        instr(K_ALU, 1, 0, 0, 0, 0, 0, l1);
        check("alu_latency", l1, 4);
        idle(1'b0);
        check("alu_cnt", bus.retire_cnt, 1);

        // Load with three wait cycles in MEM
        do_reset();
        idle(1'b1);
        instr(K_LOAD, 1, 0, 0, 3, 0, 0, l1);
        check("load_latency", l1, 8);
        idle(1'b0);

        // Store then taken branch, back to back
        do_reset();
        idle(1'b1);
        instr(K_STORE, 0, 0, 0, 0, 1, 0, l1);
        instr(K_BR,    0, 1, 0, 0, 0, 0, l2);
        check("store_branch_latency", l1 + l2, 7);
        idle(1'b0);
        check("store_branch_cnt", bus.retire_cnt, 2);

        // Jal with link write; run dropped in DECODE
        do_reset();
        idle(1'b1);
        instr(K_JMP, 1, 0, 0, 0, 0, 0, l1);
        check("jal_latency", l1, 3);
        idle(1'b0);
        check("jal_busy", bus.busy, 1'b0);

        // Mixed back-to-back patterns including longest non-faulting waits
        idle(1'b1);
        instr(K_BR,    1, 0, 0,  0,  1, 0, l1);
        instr(K_JBR,   0, 1, 2,  0,  1, 0, l1);
        instr(K_ALU,   0, 0, 15, 0,  1, 0, l1);
        check("alu_fw15_latency", l1, 19);
        instr(K_LOAD,  0, 0, 10, 10, 1, 0, l1);
        instr(K_STORE, 1, 0, 0,  15, 1, 0, l1);
        check("store_mw15_latency", l1, 19);
        instr(K_ALU,   1, 0, 1,  0,  0, 0, l1);
        idle(1'b0);
        check("mixed_cnt", bus.retire_cnt, 7);

        // Retire counter wrap at 2^CNT_W
        do_reset();
        idle(1'b1);
        for (int n = 0; n < 16; n++) instr(K_BR, 0, n[0], 0, 0, (n != 15), 0, l1);
        idle(1'b0);
        check("wrap_cnt0", bus.retire_cnt, 0);
        idle(1'b1);
        instr(K_BR, 0, 0, 0, 0, 0, 0, l1);
        idle(1'b0);
        check("wrap_cnt1", bus.retire_cnt, 1);

        // Fetch timeout
        do_reset();
        idle(1'b1);
        instr(K_ALU, 0, 0, 40, 0, 1, 0, l1);
        check("fetch_to_cycles", l1, 16);
        check("fetch_to_state", bus.state, ST_FAULT);
        check("fetch_to_req", bus.mem_req, 1'b0);

        // Data-access timeout
        do_reset();
        idle(1'b1);
        instr(K_LOAD, 1, 0, 0, 40, 1, 0, l1);
        check("mem_to_cycles", l1, 19);
        check("mem_to_fault", bus.fault, 1'b1);

        // Reset during a store in MEM
        do_reset();
        idle(1'b1);
        instr(K_STORE, 0, 0, 0, 5, 1, 1, l1);
        do_reset();
        idle(1'b0);
        check("post_rst_cnt", bus.retire_cnt, 0);
        check("post_rst_fault", bus.fault, 1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
